pipemdu: RTL and testbench

//  Execute-stage consumer of the D/E pipeline register outputs: an iterative multiply/divide unit
//  for MULT/MULTU/DIV/DIVU with architectural HI/LO registers and MTHI/MTLO writes.

---
 rtl/pipemdu.sv | 165 ++++++++++++++++
 tb/tb_pipemdu.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipemdu.sv
// Iterative multiply/divide unit with architectural HI/LO for the execute stage.
// One shift-add or restoring-divide step per clock; stalls the front of the pipe while busy.
module pipemdu #(
  parameter int              XLEN    = 32,
  parameter logic [XLEN-1:0] DIV0_LO = {XLEN{1'b1}}
) (
  input  logic            clock,
  input  logic            resetn,
  input  logic            estart,
  input  logic [1:0]      emdop,
  input  logic [XLEN-1:0] ea,
  input  logic [XLEN-1:0] eb,
  input  logic            ewhi,
  input  logic            ewlo,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo,
  output logic            mdubusy,
  output logic            mdudone
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] LAST_CNT = CW'(XLEN - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic [XLEN-1:0]   dvd_q, dvd_d;
  logic              is_div_q, is_div_d;
  logic              neg_res_q, neg_res_d;
  logic              neg_rem_q, neg_rem_d;
  logic              div0_q, div0_d;
  logic [XLEN-1:0]   hi_q, hi_d;
  logic [XLEN-1:0]   lo_q, lo_d;
  logic              done_q, done_d;

  logic              op_div, op_signed, op_div0;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  logic [XLEN:0]     div_shift, div_diff;
  logic              div_ge;
  logic [XLEN-1:0]   div_rem;
  logic [2*XLEN-1:0] div_next;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix;

  // acc holds {partial product, multiplier} for multiply and {remainder, dividend/quotient} for divide
  always_comb begin
    op_div    = emdop[1];
    op_signed = emdop[0];
    op_div0   = op_div && (eb == '0);
    a_mag     = (op_signed && ea[XLEN-1]) ? (~ea + 1'b1) : ea;
    b_mag     = (op_signed && eb[XLEN-1]) ? (~eb + 1'b1) : eb;

    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, (acc_q[0] ? opnd_q : {XLEN{1'b0}})};
    mul_next  = {mul_sum, acc_q[XLEN-1:1]};

    div_shift = acc_q[2*XLEN-1:XLEN-1];
    div_diff  = div_shift - {1'b0, opnd_q};
    div_ge    = (div_shift >= {1'b0, opnd_q});
    div_rem   = div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
    div_next  = {div_rem, acc_q[XLEN-2:0], div_ge};

    prod_fix  = neg_res_q ? (~acc_q + 1'b1) : acc_q;
    quo_fix   = neg_res_q ? (~acc_q[XLEN-1:0] + 1'b1) : acc_q[XLEN-1:0];
    rem_fix   = neg_rem_q ? (~acc_q[2*XLEN-1:XLEN] + 1'b1) : acc_q[2*XLEN-1:XLEN];
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    dvd_d     = dvd_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    div0_d    = div0_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (estart) begin
          is_div_d  = op_div;
          neg_res_d = op_signed && (ea[XLEN-1] ^ eb[XLEN-1]);
          neg_rem_d = op_signed && ea[XLEN-1];
          div0_d    = op_div0;
          dvd_d     = ea;
          opnd_d    = op_div ? b_mag : a_mag;
          acc_d     = {{XLEN{1'b0}}, (op_div ? a_mag : b_mag)};
          cnt_d     = '0;
          state_d   = op_div0 ? FIX : CALC;
        end else begin
          if (ewhi) hi_d = ea;
          if (ewlo) lo_d = ea;
        end
      end
      CALC: begin
        acc_d = is_div_q ? div_next : mul_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) state_d = FIX;
      end
      FIX: begin
        if (div0_q) begin
          hi_d = dvd_q;
          lo_d = DIV0_LO;
        end else if (is_div_q) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end else begin
          hi_d = prod_fix[2*XLEN-1:XLEN];
          lo_d = prod_fix[XLEN-1:0];
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      dvd_q     <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      dvd_q     <= dvd_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      div0_q    <= div0_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  assign hi      = hi_q;
  assign lo      = lo_q;
  assign mdubusy = (state_q != IDLE);
  assign mdudone = done_q;

endmodule

// File: tb/tb_pipemdu.sv
// Randomized bench for pipemdu: a cycle-level behavioural model computes HI/LO with plain
// 64-bit arithmetic and a busy countdown, checked every cycle, plus literal directed results.
module tb_pipemdu;

  logic        clock = 1'b0;
  logic        resetn;
  logic        estart;
  logic [1:0]  emdop;
  logic [31:0] ea, eb;
  logic        ewhi, ewlo;
  logic [31:0] hi, lo;
  logic        mdubusy, mdudone;

  int vectors = 0;
  int miscompares = 0;
  bit compareEn = 1'b0;

  pipemdu #(.XLEN(32), .DIV0_LO(32'hFFFFFFFF)) dut (
    .clock(clock), .resetn(resetn), .estart(estart), .emdop(emdop),
    .ea(ea), .eb(eb), .ewhi(ewhi), .ewlo(ewlo),
    .hi(hi), .lo(lo), .mdubusy(mdubusy), .mdudone(mdudone)
  );

  always #5 clock = ~clock;

  // Behavioural model: architectural result from arithmetic, timing as a busy countdown
  logic [31:0] mHi, mLo, pendHi, pendLo;
  bit          mDone;
  int          mBusyLeft;

  function automatic void computeResult(input logic [1:0] op, input logic [31:0] a,
                                        input logic [31:0] b, output logic [31:0] rHi,
                                        output logic [31:0] rLo, output bit isDiv0);
    longint p, sa, sb, q, r;
    logic [63:0] up;
    isDiv0 = 1'b0;
    rHi = '0;
    rLo = '0;
    case (op)
      2'd0: begin
        up = {32'd0, a} * {32'd0, b};
        rHi = up[63:32]; rLo = up[31:0];
      end
      2'd1: begin
        p = longint'($signed(a)) * longint'($signed(b));
        up = 64'(p);
        rHi = up[63:32]; rLo = up[31:0];
      end
      2'd2: begin
        if (b == 0) isDiv0 = 1'b1;
        else begin rLo = a / b; rHi = a % b; end
      end
      default: begin
        if (b == 0) isDiv0 = 1'b1;
        else begin
          sa = longint'($signed(a)); sb = longint'($signed(b));
          q = sa / sb; r = sa % sb;
          rLo = q[31:0]; rHi = r[31:0];
        end
      end
    endcase
    if (isDiv0) begin rHi = a; rLo = 32'hFFFFFFFF; end
  endfunction

  always @(posedge clock or negedge resetn) begin
    logic [31:0] rh, rl;
    bit d0;
    if (!resetn) begin
      mHi = '0; mLo = '0; mDone = 1'b0; mBusyLeft = 0;
    end else begin
      mDone = 1'b0;
      if (mBusyLeft > 0) begin
        mBusyLeft--;
        if (mBusyLeft == 0) begin
          mHi = pendHi; mLo = pendLo; mDone = 1'b1;
        end
      end else if (estart) begin
        computeResult(emdop, ea, eb, rh, rl, d0);
        pendHi = rh; pendLo = rl;
        mBusyLeft = d0 ? 1 : 33;
      end else begin
        if (ewhi) mHi = ea;
        if (ewlo) mLo = ea;
      end
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clock) begin
    if (compareEn) begin
      bit bad;
      bad = 1'b0;
      vectors++;
      if (hi !== mHi) begin
        $display("[TB] FAIL cyc_hi t=%0t actual=%h required=%h", $time, hi, mHi); bad = 1'b1;
      end
      if (lo !== mLo) begin
        $display("[TB] FAIL cyc_lo t=%0t actual=%h required=%h", $time, lo, mLo); bad = 1'b1;
      end
      if (mdubusy !== (mBusyLeft > 0)) begin
        $display("[TB] FAIL cyc_busy t=%0t actual=%b required=%b", $time, mdubusy, mBusyLeft > 0);
        bad = 1'b1;
      end
      if (mdudone !== mDone) begin
        $display("[TB] FAIL cyc_done t=%0t actual=%b required=%b", $time, mdudone, mDone);
        bad = 1'b1;
      end
      if (bad) miscompares++;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s actual=%h required=%h", name, actual, expected);
    end
  endtask

  // Issue one op from IDLE, count busy cycles, and stop on the negedge where mdudone shows
  task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a,
                               input logic [31:0] b, output int busyCycles);
    bit seen;
    @(negedge clock);
    estart = 1'b1; emdop = op; ea = a; eb = b; ewhi = 1'b0; ewlo = 1'b0;
    @(negedge clock);
    estart = 1'b0;
    busyCycles = 0;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (mdubusy) busyCycles++;
      if (mdudone) begin seen = 1'b1; break; end
      @(negedge clock);
    end
    checkOutput("op_done_seen", 32'(seen), 32'd1);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(7))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int bc;
    int doneCount;
    resetn = 1'b1; estart = 1'b0; emdop = 2'd0; ea = '0; eb = '0; ewhi = 1'b0; ewlo = 1'b0;
    #1 resetn = 1'b0;
    repeat (2) @(negedge clock);
    compareEn = 1'b1;
    checkOutput("rst_hi", hi, 32'h0);
    checkOutput("rst_lo", lo, 32'h0);
    checkOutput("rst_busy", 32'(mdubusy), 32'd0);
    checkOutput("rst_done", 32'(mdudone), 32'd0);
    #2 resetn = 1'b1;

    applyStimulus(2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, bc);
    checkOutput("multu_hi", hi, 32'hFFFFFFFE);
    checkOutput("multu_lo", lo, 32'h00000001);
    @(negedge clock);
    checkOutput("done_one_cycle", 32'(mdudone), 32'd0);

    applyStimulus(2'd1, 32'hFFFFFFFD, 32'h00000007, bc);
    checkOutput("mult_hi", hi, 32'hFFFFFFFF);
    checkOutput("mult_lo", lo, 32'hFFFFFFEB);
    checkOutput("mult_busy_cycles", 32'(bc), 32'd33);

    applyStimulus(2'd3, 32'hFFFFFFF9, 32'h00000002, bc);
    checkOutput("div_lo", lo, 32'hFFFFFFFD);
    checkOutput("div_hi", hi, 32'hFFFFFFFF);

    applyStimulus(2'd2, 32'd100, 32'd7, bc);
    checkOutput("divu_lo", lo, 32'h0000000E);
    checkOutput("divu_hi", hi, 32'h00000002);

    applyStimulus(2'd2, 32'h12345678, 32'h0, bc);
    checkOutput("div0_hi", hi, 32'h12345678);
    checkOutput("div0_lo", lo, 32'hFFFFFFFF);
    checkOutput("div0_busy_cycles", 32'(bc), 32'd1);

    applyStimulus(2'd3, 32'h80000000, 32'hFFFFFFFF, bc);
    checkOutput("divovf_lo", lo, 32'h80000000);
    checkOutput("divovf_hi", hi, 32'h00000000);

    // Second estart and MTHI while busy must not disturb the op in flight
    @(negedge clock);
    estart = 1'b1; emdop = 2'd0; ea = 32'd3; eb = 32'd5;
    @(negedge clock);
    estart = 1'b0;
    repeat (4) @(negedge clock);
    estart = 1'b1; emdop = 2'd2; ea = 32'hAAAA5555; eb = 32'd9; ewhi = 1'b1;
    @(negedge clock);
    estart = 1'b0; ewhi = 1'b0;
    for (int i = 0; i < 60 && !mdudone; i++) @(negedge clock);
    checkOutput("busy_ignore_hi", hi, 32'h0);
    checkOutput("busy_ignore_lo", lo, 32'h0000000F);
    ea = 32'hAAAA5555; ewhi = 1'b1;
    @(negedge clock);
    ewhi = 1'b0;
    checkOutput("mthi_hi", hi, 32'hAAAA5555);
    checkOutput("mthi_lo_kept", lo, 32'h0000000F);

    // Reset in the middle of a MULT
    @(negedge clock);
    estart = 1'b1; emdop = 2'd1; ea = 32'h00001234; eb = 32'hFFFF0000;
    @(negedge clock);
    estart = 1'b0;
    repeat (9) @(negedge clock);
    #2 resetn = 1'b0;
    #1;
    checkOutput("midrst_hi", hi, 32'h0);
    checkOutput("midrst_lo", lo, 32'h0);
    checkOutput("midrst_busy", 32'(mdubusy), 32'd0);
    @(negedge clock);
    #2 resetn = 1'b1;
    doneCount = 0;
    repeat (40) begin
      @(negedge clock);
      if (mdudone) doneCount++;
    end
    checkOutput("midrst_no_done", 32'(doneCount), 32'd0);
    applyStimulus(2'd1, 32'h00001234, 32'hFFFF0000, bc);
    checkOutput("post_rst_hi", hi, 32'hFFFFFFFF);
    checkOutput("post_rst_lo", lo, 32'hEDCC0000);

    // Randomized traffic: every input randomized each cycle, model tracks everything
    for (int c = 0; c < 4000; c++) begin
      @(negedge clock);
      estart = ($urandom_range(5) == 0);
      emdop  = 2'($urandom_range(3));
      ea     = pick();
      eb     = ($urandom_range(9) == 0) ? 32'h0 : pick();
      ewhi   = ($urandom_range(3) == 0);
      ewlo   = ($urandom_range(3) == 0);
      if (c == 2000) begin
        #2 resetn = 1'b0;
        #4 resetn = 1'b1;
      end
    end
    @(negedge clock);
    estart = 1'b0; ewhi = 1'b0; ewlo = 1'b0;
    repeat (40) @(negedge clock);

    compareEn = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
